// File: rtl/ga23_sdr_responder.sv
// ga23_sdr_responder: SDRAM-side responder for the GA23 tile-layer fetch port.
// Each layer port issues one-clock sdr_req/sdr_addr strobes; one request per
// port is queued and served round-robin over a single req/ack SDRAM channel.
// The returned row is held on that port's sdr_data slice with an sdr_rdy pulse.
// Optional build macro: GA23_SDR_CACHE_EN adds a per-port one-entry tag/data
// cache that answers a repeated address without a memory transaction.
module ga23_sdr_responder #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 21
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          sdr_req,
    input  logic [NUM_PORTS*ADDR_W-1:0]   sdr_addr,
    output logic [NUM_PORTS*32-1:0]       sdr_data,
    output logic [NUM_PORTS-1:0]          sdr_rdy,
    output logic [NUM_PORTS-1:0]          overrun,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_req,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_data,
    output logic                          busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_PORTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   pending_q, pending_d;
    logic [ADDR_W-1:0]      addr_q [NUM_PORTS];
    logic [ADDR_W-1:0]      addr_d [NUM_PORTS];
    logic [DATA_W-1:0]      data_q [NUM_PORTS];
    logic [DATA_W-1:0]      data_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]   rdy_q, rdy_d;
    logic [NUM_PORTS-1:0]   ovr_q, ovr_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic                   mem_req_q, mem_req_d;
    logic                   busy_q, busy_d;

    logic                   any_pend_c;
    logic [PTR_W-1:0]       gnt_c;
    logic                   grant_c;
    logic                   hit_c;

`ifdef GA23_SDR_CACHE_EN
    logic [ADDR_W-1:0]      tag_q [NUM_PORTS];
    logic [ADDR_W-1:0]      tag_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]   tag_vld_q, tag_vld_d;
`endif

    // Round-robin search: first pending port after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        any_pend_c = 1'b0;
        gnt_c      = ptr_q;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = (32'(ptr_q) + i) % NUM_PORTS;
            if (!any_pend_c && pending_q[PTR_W'(idx)]) begin
                any_pend_c = 1'b1;
                gnt_c      = PTR_W'(idx);
            end
        end
    end

    // Cache lookup for the port about to be granted.
    always_comb begin
`ifdef GA23_SDR_CACHE_EN
        hit_c = tag_vld_q[gnt_c] && (tag_q[gnt_c] == addr_q[gnt_c]);
`else
        hit_c = 1'b0;
`endif
    end

    // Next-state and registered-output logic: grant/issue/complete, then capture.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdy_d      = '0;
        ovr_d      = ovr_q;
        ptr_d      = ptr_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        grant_c    = 1'b0;
`ifdef GA23_SDR_CACHE_EN
        tag_d      = tag_q;
        tag_vld_d  = tag_vld_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // mem_ack is ignored here; only a pending port moves the FSM
                if (any_pend_c) begin
                    grant_c          = 1'b1;
                    ptr_d            = gnt_c;
                    pending_d[gnt_c] = 1'b0;
                    if (hit_c) begin
                        rdy_d[gnt_c] = 1'b1;
                    end else begin
                        mem_addr_d = addr_q[gnt_c];
                        mem_req_d  = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // in-flight port is the pointer, which was set on the grant edge
                if (mem_ack) begin
                    data_d[ptr_q] = mem_data;
                    rdy_d[ptr_q]  = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = ST_IDLE;
`ifdef GA23_SDR_CACHE_EN
                    tag_d[ptr_q]     = mem_addr_q;
                    tag_vld_d[ptr_q] = 1'b1;
`endif
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // A new strobe always wins; it only counts as overrun if the old entry
        // was still waiting, i.e. not consumed by a grant on this same edge.
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (sdr_req[p]) begin
                if (pending_q[p] && !(grant_c && (gnt_c == PTR_W'(p)))) begin
                    ovr_d[p] = 1'b1;
                end
                pending_d[p] = 1'b1;
                addr_d[p]    = sdr_addr[p*ADDR_W +: ADDR_W];
            end
        end

        busy_d = (state_d == ST_ISSUE) || (|pending_d);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            rdy_q      <= '0;
            ovr_q      <= '0;
            ptr_q      <= PTR_RST;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                addr_q[p] <= '0;
                data_q[p] <= '0;
            end
`ifdef GA23_SDR_CACHE_EN
            tag_vld_q <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                tag_q[p] <= '0;
            end
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rdy_q      <= rdy_d;
            ovr_q      <= ovr_d;
            ptr_q      <= ptr_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
`ifdef GA23_SDR_CACHE_EN
            tag_vld_q <= tag_vld_d;
            tag_q     <= tag_d;
`endif
        end
    end

    // Flatten per-port data onto the packed output bus.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_data_out
        assign sdr_data[p*DATA_W +: DATA_W] = data_q[p];
    end

    assign sdr_rdy  = rdy_q;
    assign overrun  = ovr_q;
    assign mem_addr = mem_addr_q;
    assign mem_req  = mem_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ga23_sdr_responder.sv
// Directed self-checking bench for ga23_sdr_responder (NUM_PORTS=3, ADDR_W=21).
module tb_ga23_sdr_responder;

    localparam int NP = 3;
    localparam int AW = 21;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     sdr_req;
    logic [NP*AW-1:0]  sdr_addr;
    logic [NP*32-1:0]  sdr_data;
    logic [NP-1:0]     sdr_rdy;
    logic [NP-1:0]     overrun;
    logic [AW-1:0]     mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [31:0]       mem_data;
    logic              busy;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_data [NP];

    ga23_sdr_responder #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .sdr_req  (sdr_req),
        .sdr_addr (sdr_addr),
        .sdr_data (sdr_data),
        .sdr_rdy  (sdr_rdy),
        .overrun  (overrun),
        .mem_addr (mem_addr),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP*32-1:0] exp_bus();
        logic [NP*32-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[p*32 +: 32] = exp_data[p];
        return v;
    endfunction

    task automatic post(input int p, input logic [AW-1:0] a);
        sdr_req[p]           = 1'b1;
        sdr_addr[p*AW +: AW] = a;
    endtask

    task automatic do_reset();
        sdr_req  = '0;
        mem_ack  = 1'b0;
        mem_data = '0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        for (int p = 0; p < NP; p++) exp_data[p] = '0;
    endtask

    // Serve one memory fetch: expect address a, answer with d after hold cycles,
    // then expect a single-cycle rdy on port p and the updated data bus.
    task automatic fetch(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                         input int p, input int hold);
        logic [NP-1:0] oh;
        oh    = '0;
        oh[p] = 1'b1;
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
        chk({tag, "_req"},  128'(mem_req),  128'(1'b1));
        chk({tag, "_addr"}, 128'(mem_addr), 128'(a));
        repeat (hold) tick();
        chk({tag, "_hold"}, 128'({mem_req, mem_addr}), 128'({1'b1, a}));
        mem_ack  = 1'b1;
        mem_data = d;
        tick();
        mem_ack  = 1'b0;
        mem_data = '0;
        exp_data[p] = d;
        chk({tag, "_rdy"},   128'(sdr_rdy),  128'(oh));
        chk({tag, "_data"},  128'(sdr_data), 128'(exp_bus()));
        chk({tag, "_reqlo"}, 128'(mem_req),  128'(1'b0));
        tick();
        chk({tag, "_pulse"}, 128'(sdr_rdy[p]), 128'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        sdr_req  = '0;
        sdr_addr = '0;
        mem_ack  = 1'b0;
        mem_data = '0;
        for (int p = 0; p < NP; p++) exp_data[p] = '0;
        repeat (2) tick();
        reset = 1'b0;

        // reset state
        chk("rst_mem_req",  128'(mem_req),  128'(1'b0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_rdy",      128'(sdr_rdy),  128'(0));
        chk("rst_ovr",      128'(overrun),  128'(0));
        chk("rst_data",     128'(sdr_data), 128'(0));
        chk("rst_busy",     128'(busy),     128'(1'b0));

        // single request on port 0, ack three cycles after mem_req
        post(0, 21'h001A4);
        tick();
        sdr_req = '0;
        chk("t1_noreq_yet", 128'(mem_req), 128'(1'b0));
        chk("t1_busy",      128'(busy),    128'(1'b1));
        tick();
        chk("t1_grant", 128'({mem_req, mem_addr}), 128'({1'b1, 21'h001A4}));
        fetch("t1", 21'h001A4, 32'hDEADBEEF, 0, 2);
        chk("t1_idle", 128'(busy), 128'(1'b0));

        // simultaneous requests from reset: order 0,1,2
        do_reset();
        post(0, 21'h00010); post(1, 21'h00020); post(2, 21'h00030);
        tick();
        sdr_req = '0;
        fetch("s0", 21'h00010, 32'h11110000, 0, 1);
        fetch("s1", 21'h00020, 32'h22221111, 1, 0);
        fetch("s2", 21'h00030, 32'h33332222, 2, 1);
        // pointer at 2 wraps to 0 first
        post(2, 21'h00044); post(0, 21'h00040);
        tick();
        sdr_req = '0;
        fetch("w0", 21'h00040, 32'hA0A0A0A0, 0, 0);
        fetch("w2", 21'h00044, 32'hA2A2A2A2, 2, 0);

        // overrun on port 1 while port 0 is in flight
        post(0, 21'h00300);
        tick();
        sdr_req = '0;
        tick();
        chk("o_issue", 128'({mem_req, mem_addr}), 128'({1'b1, 21'h00300}));
        post(1, 21'h00100);
        tick();
        sdr_req = '0;
        post(1, 21'h00200);
        tick();
        sdr_req = '0;
        chk("o_flag", 128'(overrun), 128'(3'b010));
        fetch("o0", 21'h00300, 32'h03000300, 0, 1);
        fetch("o1", 21'h00200, 32'h02000200, 1, 0);
        repeat (3) tick();
        chk("o_single", 128'({mem_req, busy}), 128'(2'b00));
        chk("o_sticky", 128'(overrun), 128'(3'b010));

        // back-to-back on port 0: request during its own ISSUE
        post(0, 21'h00500);
        tick();
        sdr_req = '0;
        tick();
        post(0, 21'h00504);
        tick();
        sdr_req = '0;
        chk("b_no_ovr", 128'(overrun), 128'(3'b010));
        fetch("b0", 21'h00500, 32'h05000500, 0, 1);
        fetch("b1", 21'h00504, 32'h05040504, 0, 0);

        // request arriving on the grant edge of its own port: no overrun
        post(2, 21'h00600);
        tick();
        post(2, 21'h00604);
        tick();
        sdr_req = '0;
        chk("g_grant",  128'(mem_addr), 128'(21'h00600));
        chk("g_no_ovr", 128'(overrun),  128'(3'b010));
        fetch("g0", 21'h00600, 32'h06000600, 2, 0);
        fetch("g1", 21'h00604, 32'h06040604, 2, 0);

        // reset mid-transaction, then a late ack
        post(1, 21'h00700);
        tick();
        sdr_req = '0;
        tick();
        chk("r_req_up", 128'(mem_req), 128'(1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < NP; p++) exp_data[p] = '0;
        chk("r_outs", 128'({mem_req, mem_addr, sdr_rdy, overrun, busy}), 128'(0));
        chk("r_data", 128'(sdr_data), 128'(0));
        mem_ack  = 1'b1;
        mem_data = 32'h12345678;
        tick();
        mem_ack  = 1'b0;
        mem_data = '0;
        chk("r_late_ack", 128'({sdr_rdy, mem_req}), 128'(0));
        chk("r_late_data", 128'(sdr_data), 128'(0));

        // repeat of a completed address
        post(0, 21'h001A4);
        tick();
        sdr_req = '0;
        fetch("c0", 21'h001A4, 32'h0BADF00D, 0, 0);
        post(0, 21'h001A4);
        tick();
        sdr_req = '0;
        tick();
`ifdef GA23_SDR_CACHE_EN
        chk("c_hit_rdy",  128'({sdr_rdy, mem_req}), 128'({3'b001, 1'b0}));
        chk("c_hit_data", 128'(sdr_data), 128'(exp_bus()));
        tick();
        chk("c_hit_idle", 128'({sdr_rdy, mem_req, busy}), 128'(0));
`else
        chk("c_miss_req", 128'(mem_req), 128'(1'b1));
        fetch("c1", 21'h001A4, 32'h0BADF00E, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
